// File: rtl/step_ramp_gen.sv
// Trapezoidal step-rate profile generator feeding motor_driver.
// Counts synchronized step_out feedback to accelerate, cruise and decelerate over an exact step count.
module step_ramp_gen #(
  parameter int unsigned SIZE       = 64,
  parameter int unsigned COUNT_SIZE = 32
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic                  stop_in,
  input  logic [COUNT_SIZE-1:0] steps_in,
  input  logic [SIZE-1:0]       start_period_in,
  input  logic [SIZE-1:0]       min_period_in,
  input  logic [SIZE-1:0]       accel_step_in,
  input  logic                  step_in,
  output logic [SIZE-1:0]       speed_out,
  output logic                  step_enable_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [COUNT_SIZE-1:0] position_out
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCEL  = 3'd1;
  localparam logic [2:0] ST_CRUISE = 3'd2;
  localparam logic [2:0] ST_DECEL  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [2:0]            sync_q, sync_d;
  logic [SIZE-1:0]       speed_q, speed_d;
  logic                  step_en_q, step_en_d;
  logic                  done_q, done_d;
  logic [COUNT_SIZE-1:0] pos_q, pos_d;
  logic [COUNT_SIZE-1:0] rem_q, rem_d;
  logic [COUNT_SIZE-1:0] ramp_q, ramp_d;
  logic [SIZE-1:0]       start_per_q, start_per_d;
  logic [SIZE-1:0]       min_per_q, min_per_d;
  logic [SIZE-1:0]       accel_q, accel_d;

  logic                  step_edge;
  logic                  active;
  logic [COUNT_SIZE-1:0] rem_dec, pos_inc, ramp_inc;
  logic [SIZE:0]         min_plus, speed_plus;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q     <= ST_IDLE;
      sync_q      <= 3'b000;
      speed_q     <= '0;
      step_en_q   <= 1'b0;
      done_q      <= 1'b0;
      pos_q       <= '0;
      rem_q       <= '0;
      ramp_q      <= '0;
      start_per_q <= '0;
      min_per_q   <= '0;
      accel_q     <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      speed_q     <= speed_d;
      step_en_q   <= step_en_d;
      done_q      <= done_d;
      pos_q       <= pos_d;
      rem_q       <= rem_d;
      ramp_q      <= ramp_d;
      start_per_q <= start_per_d;
      min_per_q   <= min_per_d;
      accel_q     <= accel_d;
    end
  end

  // Next-state and datapath; all counters saturate instead of wrapping.
  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[1:0], step_in};
    speed_d     = speed_q;
    step_en_d   = step_en_q;
    done_d      = 1'b0;
    pos_d       = pos_q;
    rem_d       = rem_q;
    ramp_d      = ramp_q;
    start_per_d = start_per_q;
    min_per_d   = min_per_q;
    accel_d     = accel_q;

    step_edge  = sync_q[1] & ~sync_q[2];
    active     = (state_q == ST_ACCEL) || (state_q == ST_CRUISE) || (state_q == ST_DECEL);
    rem_dec    = (rem_q == '0) ? '0 : rem_q - COUNT_SIZE'(1);
    pos_inc    = (&pos_q) ? pos_q : pos_q + COUNT_SIZE'(1);
    ramp_inc   = (&ramp_q) ? ramp_q : ramp_q + COUNT_SIZE'(1);
    min_plus   = {1'b0, min_per_q} + {1'b0, accel_q};
    speed_plus = {1'b0, speed_q} + {1'b0, accel_q};

    case (state_q)
      ST_IDLE: begin
        if (start_in && !stop_in) begin
          start_per_d = start_period_in;
          min_per_d   = min_period_in;
          accel_d     = accel_step_in;
          pos_d       = '0;
          rem_d       = steps_in;
          ramp_d      = '0;
          speed_d     = start_period_in;
          if (steps_in == '0) begin
            state_d   = ST_DONE;
            step_en_d = 1'b0;
          end else if (start_period_in <= min_period_in) begin
            state_d   = ST_CRUISE;
            step_en_d = 1'b1;
          end else begin
            state_d   = ST_ACCEL;
            step_en_d = 1'b1;
          end
        end
      end
      ST_ACCEL, ST_CRUISE, ST_DECEL: begin
        if (step_edge) begin
          pos_d = pos_inc;
          rem_d = rem_dec;
        end
        if (stop_in) begin
          state_d   = ST_DONE;
          step_en_d = 1'b0;
        end else if (step_edge) begin
          if (rem_dec == '0) begin
            state_d   = ST_DONE;
            step_en_d = 1'b0;
          end else if (state_q == ST_DECEL) begin
            speed_d = (speed_plus >= {1'b0, start_per_q}) ? start_per_q : speed_plus[SIZE-1:0];
          end else if (rem_dec <= ramp_q) begin
            state_d = ST_DECEL;
          end else if (state_q == ST_ACCEL) begin
            ramp_d = ramp_inc;
            if ({1'b0, speed_q} <= min_plus) begin
              speed_d = min_per_q;
              state_d = ST_CRUISE;
            end else begin
              speed_d = speed_q - accel_q;
            end
          end
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        step_en_d = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        step_en_d = 1'b0;
      end
    endcase

    done_d = (state_d == ST_DONE);
  end

  assign speed_out       = speed_q;
  assign step_enable_out = step_en_q;
  assign busy_out        = active;
  assign done_out        = done_q;
  assign position_out    = pos_q;

endmodule

// File: tb/tb_step_ramp_gen.sv
// Directed bench for step_ramp_gen: trapezoid, short, degenerate, abort, synchronizer and reset cases.
module tb_step_ramp_gen;

  logic        clk_in = 1'b0;
  logic        reset_in, start_in, stop_in, step_in;
  logic [31:0] steps_in;
  logic [63:0] start_period_in, min_period_in, accel_step_in;
  logic [63:0] speed_out;
  logic        step_enable_out, busy_out, done_out;
  logic [31:0] position_out;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int en_seen = 0;

  step_ramp_gen dut (
    .clk_in(clk_in), .reset_in(reset_in), .start_in(start_in), .stop_in(stop_in),
    .steps_in(steps_in), .start_period_in(start_period_in), .min_period_in(min_period_in),
    .accel_step_in(accel_step_in), .step_in(step_in), .speed_out(speed_out),
    .step_enable_out(step_enable_out), .busy_out(busy_out), .done_out(done_out),
    .position_out(position_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (done_out === 1'b1) done_cnt++;
    if (step_enable_out === 1'b1) en_seen++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Rising step_in; returns right after the cycle where the edge is counted.
  task automatic step_rise();
    step_in = 1'b1;
    cyc(3);
  endtask

  task automatic step_low();
    step_in = 1'b0;
    cyc(3);
  endtask

  task automatic launch(input logic [31:0] n, input logic [63:0] sp, input logic [63:0] mp,
                        input logic [63:0] ac);
    steps_in = n; start_period_in = sp; min_period_in = mp; accel_step_in = ac;
    start_in = 1'b1;
    cyc(1);
    start_in = 1'b0;
  endtask

  logic [63:0] trap_exp [10];
  logic [63:0] short_exp [4];
  int d0;

  initial begin
    trap_exp  = '{64'd100, 64'd90, 64'd80, 64'd70, 64'd60, 64'd60, 64'd60, 64'd70, 64'd80, 64'd90};
    short_exp = '{64'd100, 64'd90, 64'd80, 64'd80};
    reset_in = 1'b1; start_in = 1'b0; stop_in = 1'b0; step_in = 1'b0;
    steps_in = '0; start_period_in = '0; min_period_in = '0; accel_step_in = '0;
    cyc(2);
    reset_in = 1'b0;
    check("rst_speed", speed_out, 0);
    check("rst_en", step_enable_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_pos", position_out, 0);

    // Trapezoid, with an ignored start mid-move.
    d0 = done_cnt;
    launch(10, 100, 60, 10);
    check("trap_busy", busy_out, 1);
    check("trap_en", step_enable_out, 1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("trap_speed%0d", i + 1), speed_out, trap_exp[i]);
      if (i == 5) begin
        steps_in = 3; start_period_in = 200;
        start_in = 1'b1;
        cyc(1);
        start_in = 1'b0;
        check("trap_start_ignored", speed_out, 60);
      end
      step_rise();
      if (i < 9) step_low();
    end
    check("trap_done", done_out, 1);
    check("trap_en_off", step_enable_out, 0);
    check("trap_pos", position_out, 10);
    check("trap_speed_hold", speed_out, 90);
    cyc(1);
    check("trap_done_1cyc", done_out, 0);
    check("trap_done_cnt", done_cnt - d0, 1);
    step_low();

    // Short move never reaches cruise.
    launch(4, 100, 60, 10);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("short_speed%0d", i + 1), speed_out, short_exp[i]);
      step_rise();
      if (i < 3) begin
        check($sformatf("short_nodone%0d", i + 1), done_out, 0);
        step_low();
      end
    end
    check("short_done", done_out, 1);
    check("short_pos", position_out, 4);
    step_low();

    // Zero-length move.
    en_seen = 0;
    launch(0, 100, 60, 10);
    check("zero_done", done_out, 1);
    check("zero_busy", busy_out, 0);
    cyc(1);
    check("zero_done_1cyc", done_out, 0);
    check("zero_en_never", en_seen, 0);

    // Start period already at or below min: cruise throughout.
    launch(3, 50, 60, 10);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("flat_speed%0d", i + 1), speed_out, 50);
      step_rise();
      if (i < 2) step_low();
    end
    check("flat_done", done_out, 1);
    step_low();

    // Abort after three steps.
    launch(10, 100, 60, 10);
    for (int i = 0; i < 3; i++) begin step_rise(); step_low(); end
    stop_in = 1'b1;
    cyc(1);
    stop_in = 1'b0;
    check("abort_en", step_enable_out, 0);
    check("abort_done", done_out, 1);
    check("abort_pos", position_out, 3);
    cyc(1);
    check("abort_done_1cyc", done_out, 0);

    // Abort coincident with a counted step edge.
    launch(10, 100, 60, 10);
    for (int i = 0; i < 3; i++) begin step_rise(); step_low(); end
    step_in = 1'b1;
    cyc(2);
    stop_in = 1'b1;
    cyc(1);
    stop_in = 1'b0;
    check("abort_edge_pos", position_out, 4);
    check("abort_edge_done", done_out, 1);
    step_low();

    // Synchronizer latency and held-high step_in.
    launch(10, 100, 60, 10);
    step_in = 1'b1;
    cyc(2);
    check("sync_lat2", position_out, 0);
    cyc(1);
    check("sync_lat3", position_out, 1);
    cyc(5);
    check("sync_held", position_out, 1);
    step_low();

    // Reset in mid-cruise: no done pulse.
    for (int i = 0; i < 4; i++) begin step_rise(); step_low(); end
    check("pre_rst_speed", speed_out, 60);
    d0 = done_cnt;
    reset_in = 1'b1;
    cyc(1);
    reset_in = 1'b0;
    check("mrst_speed", speed_out, 0);
    check("mrst_en", step_enable_out, 0);
    check("mrst_busy", busy_out, 0);
    check("mrst_done", done_out, 0);
    check("mrst_pos", position_out, 0);
    cyc(2);
    check("mrst_no_done", done_cnt - d0, 0);

    // Stop and start together in idle: nothing starts.
    steps_in = 5; start_period_in = 100; min_period_in = 60; accel_step_in = 10;
    start_in = 1'b1; stop_in = 1'b1;
    cyc(1);
    start_in = 1'b0; stop_in = 1'b0;
    check("ss_busy", busy_out, 0);
    check("ss_en", step_enable_out, 0);
    check("ss_done", done_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
